// File: rtl/spi_slave_out_pkg.sv
// Shared types for spi_slave_out: FSM state
// encoding and synchroniser depth.
package spi_slave_out_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_slave_out_sync.sv
// sync_edge: SYNC_DEPTH-flop synchroniser with rise/fall pulses.
// Ports: clk, reset (sync, high), din (async in),
//   level (synchronised), rise/fall (1-cycle pulses).
module sync_edge
  import spi_slave_out_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_DEPTH{RST_VAL}};
      last <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], din};
      last <= sync[SYNC_DEPTH-1];
    end
  end

  // Pulses are decoded from two flops only, so
  // they are glitch-free and cost no extra cycle.
  assign level = sync[SYNC_DEPTH-1];
  assign rise  = level & ~last;
  assign fall  = ~level & last;

endmodule

// File: rtl/spi_slave_out.sv
// SPI mode-0 transmit-only slave, MSB first.
// Ports: clk, reset (sync, high), cs (low active), sck,
//   miso, in_buf/load (shadow word), busy, done, abort.
// Option: SPI_SLAVE_OUT_PARITY_EN appends an odd-parity bit.
module spi_slave_out
  import spi_slave_out_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            sck,
  output logic            miso,
  input  logic [BITS-1:0] in_buf,
  input  logic            load,
  output logic            busy,
  output logic            done,
  output logic            abort
);

`ifdef SPI_SLAVE_OUT_PARITY_EN
  localparam int LAST = BITS + 1;
`else
  localparam int LAST = BITS;
`endif
  // One count above LAST so overrun is distinct
  // from a complete frame after saturation.
  localparam int CMAX = LAST + 1;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(LAST);
  localparam logic [CW-1:0] C_MAX  = CW'(CMAX);
`ifdef SPI_SLAVE_OUT_PARITY_EN
  localparam logic [CW-1:0] C_PAR  = CW'(BITS - 1);
  logic par_q, par_d;
`endif

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic unused_sck;

  state_t          state_q, state_d;
  logic [BITS-1:0] sr_q, sr_d;
  logic [BITS-1:0] shadow_q, shadow_d;
  logic [BITS-1:0] word;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            miso_q, miso_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic            armed_q, armed_d;
  logic [SYNC_DEPTH-1:0] settle_q, settle_d;

  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk   (clk),
    .reset (reset),
    .din   (sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign unused_sck = sck_rise ^ sck_level;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    miso_d   = miso_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    settle_d = settle_q << 1;
    word     = load ? in_buf : shadow_q;
`ifdef SPI_SLAVE_OUT_PARITY_EN
    par_d    = par_q;
`endif
    // After reset the synchroniser must refill and
    // show cs high before a falling edge counts.
    armed_d  = armed_q |
               ((settle_q == '0) & cs_level);
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (load) shadow_d = in_buf;
        if (cs_fall && armed_q) begin
          state_d = SHIFT;
          sr_d    = word;
          cnt_d   = '0;
          miso_d  = word[BITS-1];
`ifdef SPI_SLAVE_OUT_PARITY_EN
          par_d   = ~^word;
`endif
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
          miso_d  = 1'b0;
          done_d  = (cnt_q == C_LAST);
          abort_d = (cnt_q != C_LAST);
        end else if (sck_fall) begin
          sr_d   = sr_q << 1;
          miso_d = sr_q[BITS-2];
          if (cnt_q != C_MAX) cnt_d = cnt_q + 1'b1;
`ifdef SPI_SLAVE_OUT_PARITY_EN
          if (cnt_q == C_PAR) miso_d = par_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      miso_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= '1;
`ifdef SPI_SLAVE_OUT_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      miso_q   <= miso_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      armed_q  <= armed_d;
      settle_q <= settle_d;
`ifdef SPI_SLAVE_OUT_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign miso  = miso_q;
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
  assign abort = abort_q;

endmodule
